ps2_mouse_sequencer: RTL and testbench

Sequences the PS/2 controller to bring up a PS/2 mouse and then turns its stream of received bytes into movement packets for the aiming logic. It sits between `PS2_Controller` and the game/crosshair logic. Bring-up is: reset the mouse, wait for its self-test result, enable streaming, with retry on failure. In streaming mode it aligns and validates 3-byte packets and emits one decoded packet per pulse.

---
 rtl/ps2_mouse_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_ps2_mouse_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse bring-up sequencer (reset, self-test, enable streaming, with retries) and 3-byte packet decoder.
// Define PS2_MOUSE_SAMPLE_RATE_EN to insert a set-sample-rate exchange (0xF3, SAMPLE_RATE) before 0xF4.
module ps2_mouse_sequencer #(
  parameter int         TIMEOUT_CYCLES = 25_000_000,
  parameter int         MAX_RETRIES    = 3,
  parameter logic [7:0] SAMPLE_RATE    = 8'd40
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] cmd_data,
  output logic       cmd_send,
  input  logic       cmd_sent,
  input  logic       cmd_error,
  output logic       ready,
  output logic       init_failed,
  output logic       pkt_valid,
  output logic [8:0] pkt_dx,
  output logic [8:0] pkt_dy,
  output logic [2:0] pkt_buttons,
  output logic [1:0] pkt_ovf
);

  localparam logic [7:0]  CMD_RESET  = 8'hFF;
  localparam logic [7:0]  CMD_ENABLE = 8'hF4;
  localparam logic [7:0]  RSP_ACK    = 8'hFA;
  localparam logic [7:0]  RSP_RESEND = 8'hFE;
  localparam logic [7:0]  RSP_BAT    = 8'hAA;
  localparam logic [7:0]  RSP_ID     = 8'h00;
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  FAIL_LAST  = 8'(MAX_RETRIES - 1);

`ifdef PS2_MOUSE_SAMPLE_RATE_EN
  localparam logic [7:0]  CMD_SET_SR = 8'hF3;
`else
  logic w_unused_sample_rate;
  assign w_unused_sample_rate = ^SAMPLE_RATE;
`endif

  typedef enum logic [3:0] {
    SEND_RST,
    WAIT_ACK_RST,
    WAIT_BAT,
    WAIT_ID,
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
    SEND_SR,
    WAIT_ACK_SR,
    SEND_SRV,
    WAIT_ACK_SRV,
`endif
    SEND_EN,
    WAIT_ACK_EN,
    STREAM_B0,
    STREAM_B1,
    STREAM_B2,
    FAILED
  } state_t;

  function automatic logic is_send(input state_t s);
    case (s)
      SEND_RST, SEND_EN: return 1'b1;
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
      SEND_SR, SEND_SRV: return 1'b1;
`endif
      default:           return 1'b0;
    endcase
  endfunction

  function automatic logic is_ack_wait(input state_t s);
    case (s)
      WAIT_ACK_RST, WAIT_ACK_EN:  return 1'b1;
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
      WAIT_ACK_SR, WAIT_ACK_SRV:  return 1'b1;
`endif
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic is_wait(input state_t s);
    return is_ack_wait(s) || (s == WAIT_BAT) || (s == WAIT_ID);
  endfunction

  function automatic logic is_stream(input state_t s);
    return (s == STREAM_B0) || (s == STREAM_B1) || (s == STREAM_B2);
  endfunction

  function automatic logic [7:0] cmd_of(input state_t s);
    case (s)
      SEND_RST: return CMD_RESET;
      SEND_EN:  return CMD_ENABLE;
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
      SEND_SR:  return CMD_SET_SR;
      SEND_SRV: return SAMPLE_RATE;
`endif
      default:  return 8'h00;
    endcase
  endfunction

  function automatic state_t wait_of(input state_t s);
    case (s)
      SEND_RST: return WAIT_ACK_RST;
      SEND_EN:  return WAIT_ACK_EN;
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
      SEND_SR:  return WAIT_ACK_SR;
      SEND_SRV: return WAIT_ACK_SRV;
`endif
      default:  return s;
    endcase
  endfunction

  function automatic logic [7:0] expect_of(input state_t s);
    case (s)
      WAIT_BAT: return RSP_BAT;
      WAIT_ID:  return RSP_ID;
      default:  return RSP_ACK;
    endcase
  endfunction

  function automatic state_t advance_of(input state_t s);
    case (s)
      WAIT_ACK_RST: return WAIT_BAT;
      WAIT_BAT:     return WAIT_ID;
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
      WAIT_ID:      return SEND_SR;
      WAIT_ACK_SR:  return SEND_SRV;
      WAIT_ACK_SRV: return SEND_EN;
`else
      WAIT_ID:      return SEND_EN;
`endif
      WAIT_ACK_EN:  return STREAM_B0;
      default:      return SEND_RST;
    endcase
  endfunction

  function automatic state_t resend_of(input state_t s);
    case (s)
      WAIT_ACK_EN:  return SEND_EN;
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
      WAIT_ACK_SR:  return SEND_SR;
      WAIT_ACK_SRV: return SEND_SRV;
`endif
      default:      return SEND_RST;
    endcase
  endfunction

  state_t      r_state;
  logic [7:0]  r_fail_cnt;
  logic [31:0] r_to_cnt;
  logic        r_cmd_send;
  logic [7:0]  r_cmd_data;
  logic        r_ready;
  logic        r_init_failed;
  logic [1:0]  r_hdr_ovf;
  logic [1:0]  r_hdr_sign;
  logic [2:0]  r_hdr_btn;
  logic [7:0]  r_x;
  logic        r_pkt_valid;
  logic [8:0]  r_pkt_dx;
  logic [8:0]  r_pkt_dy;
  logic [2:0]  r_pkt_btn;
  logic [1:0]  r_pkt_ovf;

  state_t      w_state_nx;
  state_t      w_eval_state;
  state_t      w_fail_tgt;
  logic        w_fail;
  logic        w_req_done;
  logic        w_hdr_load;
  logic        w_x_load;
  logic        w_publish;
  logic [7:0]  w_fail_cnt_nx;
  logic [31:0] w_to_cnt_nx;
  logic        w_cmd_send_nx;
  logic        w_timed;
  logic        w_to_hit;

  assign w_timed  = is_wait(r_state) || (r_state == STREAM_B1) || (r_state == STREAM_B2);
  assign w_to_hit = w_timed && (r_to_cnt == TO_LAST);

  // Next-state decode; a byte arriving with cmd_sent is judged by the WAIT state being entered.
  always_comb begin
    w_state_nx    = r_state;
    w_eval_state  = r_state;
    w_fail        = 1'b0;
    w_fail_tgt    = SEND_RST;
    w_req_done    = 1'b0;
    w_hdr_load    = 1'b0;
    w_x_load      = 1'b0;
    w_publish     = 1'b0;
    w_fail_cnt_nx = r_fail_cnt;
    w_to_cnt_nx   = 32'd0;

    if (is_send(r_state) && r_cmd_send && cmd_sent) begin
      w_req_done   = 1'b1;
      w_eval_state = wait_of(r_state);
      w_state_nx   = wait_of(r_state);
    end else if (is_send(r_state) && r_cmd_send && cmd_error) begin
      w_req_done = 1'b1;
      w_fail     = 1'b1;
    end else begin
      w_req_done = 1'b0;
    end

    if (is_wait(w_eval_state)) begin
      if (rx_valid) begin
        if (rx_data == expect_of(w_eval_state)) begin
          w_state_nx = advance_of(w_eval_state);
        end else if (is_ack_wait(w_eval_state) && (rx_data == RSP_RESEND)) begin
          w_fail     = 1'b1;
          w_fail_tgt = resend_of(w_eval_state);
        end else begin
          w_fail = 1'b1;
        end
      end else if (w_to_hit) begin
        w_fail = 1'b1;
      end else begin
        w_fail_tgt = SEND_RST;
      end
    end else begin
      case (r_state)
        STREAM_B0: begin
          if (rx_valid && rx_data[3]) begin
            w_hdr_load = 1'b1;
            w_state_nx = STREAM_B1;
          end else begin
            w_state_nx = STREAM_B0;
          end
        end
        STREAM_B1: begin
          if (rx_valid) begin
            w_x_load   = 1'b1;
            w_state_nx = STREAM_B2;
          end else if (w_to_hit) begin
            w_state_nx = STREAM_B0;
          end else begin
            w_state_nx = STREAM_B1;
          end
        end
        STREAM_B2: begin
          if (rx_valid) begin
            w_publish  = 1'b1;
            w_state_nx = STREAM_B0;
          end else if (w_to_hit) begin
            w_state_nx = STREAM_B0;
          end else begin
            w_state_nx = STREAM_B2;
          end
        end
        default: begin
          w_hdr_load = 1'b0;
        end
      endcase
    end

    if (w_fail) begin
      if (r_fail_cnt >= FAIL_LAST) begin
        w_state_nx = FAILED;
      end else begin
        w_state_nx    = w_fail_tgt;
        w_fail_cnt_nx = r_fail_cnt + 8'd1;
      end
    end else if (is_stream(w_state_nx)) begin
      w_fail_cnt_nx = 8'd0;
    end else begin
      w_fail_cnt_nx = r_fail_cnt;
    end

    if ((w_state_nx != r_state) || rx_valid || !w_timed) begin
      w_to_cnt_nx = 32'd0;
    end else begin
      w_to_cnt_nx = r_to_cnt + 32'd1;
    end

    w_cmd_send_nx = is_send(w_state_nx) && !w_req_done;
  end

  // Sequencer state, counters and command/status outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state       <= SEND_RST;
      r_fail_cnt    <= 8'd0;
      r_to_cnt      <= 32'd0;
      r_cmd_send    <= 1'b0;
      r_cmd_data    <= 8'h00;
      r_ready       <= 1'b0;
      r_init_failed <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_fail_cnt    <= w_fail_cnt_nx;
      r_to_cnt      <= w_to_cnt_nx;
      r_cmd_send    <= w_cmd_send_nx;
      if (is_send(w_state_nx)) begin
        r_cmd_data <= cmd_of(w_state_nx);
      end
      r_ready       <= is_stream(w_state_nx);
      r_init_failed <= r_init_failed | (w_state_nx == FAILED);
    end
  end

  // Packet assembly; fields publish together with the valid pulse and hold until the next packet.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_hdr_ovf   <= 2'd0;
      r_hdr_sign  <= 2'd0;
      r_hdr_btn   <= 3'd0;
      r_x         <= 8'd0;
      r_pkt_valid <= 1'b0;
      r_pkt_dx    <= 9'd0;
      r_pkt_dy    <= 9'd0;
      r_pkt_btn   <= 3'd0;
      r_pkt_ovf   <= 2'd0;
    end else begin
      r_pkt_valid <= w_publish;
      if (w_hdr_load) begin
        r_hdr_ovf  <= rx_data[7:6];
        r_hdr_sign <= rx_data[5:4];
        r_hdr_btn  <= rx_data[2:0];
      end
      if (w_x_load) begin
        r_x <= rx_data;
      end
      if (w_publish) begin
        r_pkt_dx  <= {r_hdr_sign[0], r_x};
        r_pkt_dy  <= {r_hdr_sign[1], rx_data};
        r_pkt_btn <= r_hdr_btn;
        r_pkt_ovf <= r_hdr_ovf;
      end
    end
  end

  assign cmd_data    = r_cmd_data;
  assign cmd_send    = r_cmd_send;
  assign ready       = r_ready;
  assign init_failed = r_init_failed;
  assign pkt_valid   = r_pkt_valid;
  assign pkt_dx      = r_pkt_dx;
  assign pkt_dy      = r_pkt_dy;
  assign pkt_buttons = r_pkt_btn;
  assign pkt_ovf     = r_pkt_ovf;

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Directed bench for ps2_mouse_sequencer: acts as the PS/2 controller and mouse, and checks outputs
// every cycle against a byte-level packet model plus literal expectations.
module tb_ps2_mouse_sequencer;

  localparam int TO = 16;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_sent = 1'b0;
  logic       cmd_error = 1'b0;
  logic [7:0] cmd_data;
  logic       cmd_send;
  logic       ready;
  logic       init_failed;
  logic       pkt_valid;
  logic [8:0] pkt_dx;
  logic [8:0] pkt_dy;
  logic [2:0] pkt_buttons;
  logic [1:0] pkt_ovf;

  always #5 clk = ~clk;

  ps2_mouse_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MR),
    .SAMPLE_RATE(8'd40)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .cmd_data(cmd_data),
    .cmd_send(cmd_send),
    .cmd_sent(cmd_sent),
    .cmd_error(cmd_error),
    .ready(ready),
    .init_failed(init_failed),
    .pkt_valid(pkt_valid),
    .pkt_dx(pkt_dx),
    .pkt_dy(pkt_dy),
    .pkt_buttons(pkt_buttons),
    .pkt_ovf(pkt_ovf)
  );

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // expectation model
  bit         chk_en = 1'b0;
  logic       exp_ready = 1'b0;
  logic       exp_failed = 1'b0;
  logic [8:0] exp_dx = 9'd0;
  logic [8:0] exp_dy = 9'd0;
  logic [2:0] exp_btn = 3'd0;
  logic [1:0] exp_ovf = 2'd0;
  longint     exp_pkt_cyc = -1;
  int         m_phase = 0;
  logic [7:0] m_hdr = 8'h00;
  logic [7:0] m_x = 8'h00;
  longint     m_last = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] to_move(input logic sgn, input logic [7:0] mag);
    int v;
    v = sgn ? (int'(mag) - 256) : int'(mag);
    return 9'(v);
  endfunction

  task automatic model_reset();
    exp_ready   = 1'b0;
    exp_failed  = 1'b0;
    exp_dx      = 9'd0;
    exp_dy      = 9'd0;
    exp_btn     = 3'd0;
    exp_ovf     = 2'd0;
    exp_pkt_cyc = -1;
    m_phase     = 0;
  endtask

  // called just after the edge that consumed byte b while streaming
  task automatic model_byte(input logic [7:0] b);
    if (m_phase != 0 && (cyc - m_last) > TO) m_phase = 0;
    m_last = cyc;
    case (m_phase)
      0: begin
        if (b[3]) begin
          m_hdr   = b;
          m_phase = 1;
        end
      end
      1: begin
        m_x     = b;
        m_phase = 2;
      end
      default: begin
        exp_dx      = to_move(m_hdr[4], m_x);
        exp_dy      = to_move(m_hdr[5], b);
        exp_btn     = m_hdr[2:0];
        exp_ovf     = m_hdr[7:6];
        exp_pkt_cyc = cyc;
        m_phase     = 0;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("init_failed", 32'(init_failed), 32'(exp_failed));
      chk("pkt_valid", 32'(pkt_valid), 32'(cyc == exp_pkt_cyc));
      chk("pkt_dx", 32'(pkt_dx), 32'(exp_dx));
      chk("pkt_dy", 32'(pkt_dy), 32'(exp_dy));
      chk("pkt_buttons", 32'(pkt_buttons), 32'(exp_btn));
      chk("pkt_ovf", 32'(pkt_ovf), 32'(exp_ovf));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (exp_ready) model_byte(b);
  endtask

  // mode 0: ack; mode 1: ack with coincident response byte b; mode 2: leave request pending
  task automatic expect_cmd(input string tag, input logic [7:0] c, input int mode, input logic [7:0] b);
    int n = 0;
    while (cmd_send !== 1'b1 && n < TO + 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_send"}, 32'(cmd_send), 32'd1);
    chk({tag, "_data"}, 32'(cmd_data), 32'(c));
    if (mode != 2) begin
      cmd_sent = 1'b1;
      if (mode == 1) begin
        rx_data  = b;
        rx_valid = 1'b1;
      end
      @(posedge clk); #1;
      cmd_sent = 1'b0;
      rx_valid = 1'b0;
      chk({tag, "_drop"}, 32'(cmd_send), 32'd0);
    end
  endtask

  task automatic bringup_tail(input bit coinc);
    push_byte(8'hFA);
    push_byte(8'hAA);
    push_byte(8'h00);
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
    expect_cmd("sr", 8'hF3, 0, 8'h00);
    push_byte(8'hFA);
    expect_cmd("srv", 8'h28, 0, 8'h00);
    push_byte(8'hFA);
`endif
    if (coinc) begin
      expect_cmd("en", 8'hF4, 1, 8'hFA);
    end else begin
      expect_cmd("en", 8'hF4, 0, 8'h00);
      push_byte(8'hFA);
    end
    exp_ready = 1'b1;
    m_phase   = 0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    rx_valid  = 1'b0;
    cmd_sent  = 1'b0;
    cmd_error = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk({tag, "_cmd_send"}, 32'(cmd_send), 32'd0);
    chk({tag, "_cmd_data"}, 32'(cmd_data), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_init_failed"}, 32'(init_failed), 32'd0);
    chk({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
    chk({tag, "_pkt_dx"}, 32'(pkt_dx), 32'd0);
    chk({tag, "_pkt_dy"}, 32'(pkt_dy), 32'd0);
    chk({tag, "_pkt_buttons"}, 32'(pkt_buttons), 32'd0);
    chk({tag, "_pkt_ovf"}, 32'(pkt_ovf), 32'd0);
    model_reset();
    chk_en = 1'b0;
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_send", 32'(cmd_send), 32'd0);
    chk("rst_cmd_data", 32'(cmd_data), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_init_failed", 32'(init_failed), 32'd0);
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_pkt_dx", 32'(pkt_dx), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // bring-up with a resend request after the first 0xFF
    expect_cmd("rst1", 8'hFF, 0, 8'h00);
    push_byte(8'hFE);
    expect_cmd("rst_resend", 8'hFF, 0, 8'h00);
    bringup_tail(1'b0);
    idle(2);
    chk("up_ready", 32'(ready), 32'd1);

    // packet decode: header 0x18 carries the X sign bit
    push_byte(8'h18); push_byte(8'h05); push_byte(8'hFB);
    chk("p1_valid", 32'(pkt_valid), 32'd1);
    chk("p1_dx", 32'(pkt_dx), 32'h105);
    chk("p1_dy", 32'(pkt_dy), 32'h0FB);
    chk("p1_btn", 32'(pkt_buttons), 32'd0);
    push_byte(8'h28); push_byte(8'h05); push_byte(8'hFB);
    chk("p2_dx", 32'(pkt_dx), 32'h005);
    chk("p2_dy", 32'(pkt_dy), 32'h1FB);
    idle(1);
    chk("p2_valid_pulse", 32'(pkt_valid), 32'd0);

    // resync: 0x02 has bit3 clear and is dropped
    push_byte(8'h02); push_byte(8'h09); push_byte(8'h10); push_byte(8'h20);
    chk("p3_dx", 32'(pkt_dx), 32'h010);
    chk("p3_dy", 32'(pkt_dy), 32'h020);
    chk("p3_btn", 32'(pkt_buttons), 32'd1);
    push_byte(8'hFF); push_byte(8'h01); push_byte(8'hFF);
    chk("p4_dx", 32'(pkt_dx), 32'h101);
    chk("p4_dy", 32'(pkt_dy), 32'h1FF);
    chk("p4_btn", 32'(pkt_buttons), 32'd7);
    chk("p4_ovf", 32'(pkt_ovf), 32'd3);

    // mid-packet stall drops the partial packet
    push_byte(8'h08); push_byte(8'h01);
    idle(TO + 4);
    push_byte(8'h08); push_byte(8'h02); push_byte(8'h03);
    chk("p5_dx", 32'(pkt_dx), 32'h002);
    chk("p5_dy", 32'(pkt_dy), 32'h003);
    chk("p5_ovf", 32'(pkt_ovf), 32'd0);

    // asynchronous reset in the middle of a packet
    push_byte(8'h09); push_byte(8'h05);
    async_reset_check("mid_pkt");

    // bad BAT result restarts from reset; final ack arrives with cmd_sent
    expect_cmd("rst2", 8'hFF, 0, 8'h00);
    push_byte(8'hFA);
    push_byte(8'hFC);
    expect_cmd("bat_restart", 8'hFF, 0, 8'h00);
    bringup_tail(1'b1);
    idle(2);
    chk("up2_ready", 32'(ready), 32'd1);

    // asynchronous reset while a command request is pending
    do_reset();
    expect_cmd("rst3", 8'hFF, 2, 8'h00);
    idle(3);
    chk("hold_send", 32'(cmd_send), 32'd1);
    chk("hold_data", 32'(cmd_data), 32'hFF);
    async_reset_check("mid_tx");

    // three response timeouts exhaust the retries
    expect_cmd("rst4", 8'hFF, 0, 8'h00);
    chk_en = 1'b0;
    expect_cmd("to_retry1", 8'hFF, 0, 8'h00);
    expect_cmd("to_retry2", 8'hFF, 0, 8'h00);
    idle(TO + 5);
    chk("fail_init_failed", 32'(init_failed), 32'd1);
    chk("fail_cmd_send", 32'(cmd_send), 32'd0);
    chk("fail_ready", 32'(ready), 32'd0);
    exp_failed = 1'b1;
    chk_en     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("fail_no_cmd", 32'(cmd_send), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    bad++;
    $display("FAIL watchdog: run did not complete, limit 500000 reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
